// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word requests on the instruction bus and
// buffers returned words in a small in-order queue that feeds the if_id register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic [31:0]   fetch_pc_q, head_pc_q;
  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] buf_cnt_q, out_cnt_q, disc_cnt_q;

  logic          pop, fire, ret, drop, push;
  logic [CW:0]   credit;
  logic [31:0]   jump_target;
  logic          unused_jump_lsb;

  assign unused_jump_lsb = ^jump_addr_i[1:0];
  assign jump_target     = {jump_addr_i[31:2], 2'b00};

  always_comb begin
    inst_valid_o = !rst_i && (buf_cnt_q != '0);
    inst_o       = inst_valid_o ? mem_q[rd_ptr_q] : NOP;
    inst_addr_o  = rst_i ? RESET_PC : head_pc_q;
    ibus_addr_o  = rst_i ? RESET_PC : fetch_pc_q;
    pop          = inst_valid_o && !stall_i;
    // Credit counts granted-but-unreturned words plus buffered words, so the queue never overflows.
    credit       = {1'b0, out_cnt_q} + {1'b0, buf_cnt_q} - {{CW{1'b0}}, pop};
    ibus_req_o   = !rst_i && (credit < DEPTH_W);
    fire         = ibus_req_o && ibus_gnt_i;
    // Returns with nothing outstanding (e.g. stragglers from before a reset) are ignored.
    ret          = ibus_rvalid_i && !rst_i && (out_cnt_q != '0);
    drop         = ret && (disc_cnt_q != '0);
    push         = ret && !drop && !jump_flag_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      buf_cnt_q  <= '0;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
    end else begin
      out_cnt_q <= out_cnt_q + CW'(fire) - CW'(ret);
      if (jump_flag_i) begin
        // Everything still on the bus, including a grant taken this cycle, becomes stale.
        fetch_pc_q <= jump_target;
        head_pc_q  <= jump_target;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        buf_cnt_q  <= '0;
        disc_cnt_q <= out_cnt_q + CW'(fire) - CW'(ret);
      end else begin
        if (fire) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (drop) disc_cnt_q <= disc_cnt_q - 1'b1;
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop) begin
          rd_ptr_q  <= rd_ptr_q + 1'b1;
          head_pc_q <= head_pc_q + 32'd4;
        end
        buf_cnt_q <= buf_cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem_q[wr_ptr_q] <= ibus_rdata_i;
  end

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a bus model answers grants in order with a programmable
// latency, stimulus queues expected instructions and a monitor checks every popped one.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        req;
  logic [31:0] addr;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;

  if_fetch #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .jump_flag_i  (jump),
    .jump_addr_i  (jump_addr),
    .ibus_req_o   (req),
    .ibus_addr_o  (addr),
    .ibus_gnt_i   (gnt),
    .ibus_rvalid_i(rvalid),
    .ibus_rdata_i (rdata),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  logic [31:0] grant_log[$];
  int          checks = 0;
  int          failures = 0;
  int          budget = 0;
  int          lat = 1;
  bit          gnt_hold = 1'b0;
  int          cyc = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  // Bus model: in-order responses, each due a fixed latency after its grant.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = 32'h0;
    end
    gnt = (budget > 0) && !gnt_hold;
    #1;
    if (req && gnt) begin
      pend.push_back('{addr, cyc + lat});
      grant_log.push_back(addr);
      budget--;
    end
  end

  // Monitor: every instruction consumed by decode must match the head of the scoreboard.
  always begin
    @(negedge clk);
    #3;
    if (!rst && inst_valid && !stall && !jump) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_inst_addr", inst_addr, 32'hxxxx_xxxx);
      end else begin
        chk("inst_addr", inst_addr, exp_q[0].addr);
        chk("inst_data", inst, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic look();
    #4;
  endtask

  task automatic expect_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      exp_q.push_back('{a, mem_word(a)});
    end
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() > 0 || pend.size() > 0) && n < limit) begin
      step();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'h0);
    repeat (2) step();
  endtask

  initial begin
    // Reset values
    repeat (2) step();
    look();
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_addr", inst_addr, 32'h0);

    // Streaming with zero-wait bus: one instruction per cycle from the second cycle after gnt
    step();
    rst = 1'b0;
    budget = 8;
    expect_words(32'h0, 8);
    look();
    chk("first_req", {31'h0, req}, 32'h1);
    chk("first_addr", addr, 32'h0);
    step(); look();
    chk("lat_valid_t1", {31'h0, inst_valid}, 32'h0);
    step(); look();
    chk("lat_valid_t2", {31'h0, inst_valid}, 32'h1);
    chk("lat_addr_t2", inst_addr, 32'h0);
    for (int k = 1; k < 8; k++) begin
      step(); look();
      chk("stream_valid", {31'h0, inst_valid}, 32'h1);
    end
    step(); look();
    chk("stream_end_valid", {31'h0, inst_valid}, 32'h0);
    drain("drain_stream", 20);

    // Stall mid-stream: output frozen at 0x28, request withdrawn once credit is exhausted
    step();
    budget = 8;
    expect_words(32'h20, 8);
    repeat (4) step();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      look();
      chk("stall_addr", inst_addr, 32'h28);
      chk("stall_inst", inst, mem_word(32'h28));
      if (k == 2) chk("stall_req", {31'h0, req}, 32'h0);
      step();
    end
    stall = 1'b0;
    drain("drain_stall", 30);

    // Flush with two outstanding; flush coincides with the first stale return
    step();
    stall = 1'b1;
    lat = 3;
    budget = 2;
    repeat (3) step();
    jump = 1'b1;
    jump_addr = 32'h0000_0103;
    stall = 1'b0;
    step();
    jump = 1'b0;
    budget = 2;
    expect_words(32'h100, 2);
    look();
    chk("flush_addr", addr, 32'h100);
    chk("flush_req", {31'h0, req}, 32'h1);
    chk("flush_valid", {31'h0, inst_valid}, 32'h0);
    drain("drain_flush", 30);

    // Back-to-back flushes: a grant in the first flush cycle and a return in the second
    step();
    stall = 1'b1;
    lat = 2;
    budget = 2;
    step();
    jump = 1'b1;
    jump_addr = 32'h500;
    step();
    jump_addr = 32'h600;
    look();
    chk("dflush_addr1", addr, 32'h500);
    step();
    jump = 1'b0;
    stall = 1'b0;
    budget = 2;
    expect_words(32'h600, 2);
    look();
    chk("dflush_addr2", addr, 32'h600);
    drain("drain_dflush", 30);

    // Grant withheld: address stable, then a flush retargets the pending request
    step();
    lat = 1;
    gnt_hold = 1'b1;
    budget = 1;
    for (int k = 0; k < 4; k++) begin
      look();
      chk("hold_req", {31'h0, req}, 32'h1);
      chk("hold_addr", addr, 32'h608);
      step();
    end
    jump = 1'b1;
    jump_addr = 32'h200;
    step();
    jump = 1'b0;
    gnt_hold = 1'b0;
    expect_words(32'h200, 1);
    look();
    chk("hold_retarget", addr, 32'h200);
    drain("drain_hold", 20);

    // PC wrap at the top of the address space
    step();
    jump = 1'b1;
    jump_addr = 32'hFFFF_FFF8;
    grant_log.delete();
    step();
    jump = 1'b0;
    budget = 3;
    expect_words(32'hFFFF_FFF8, 3);
    drain("drain_wrap", 20);
    chk("wrap_grants", 32'(grant_log.size()), 32'h3);
    if (grant_log.size() == 3) begin
      chk("wrap_g0", grant_log[0], 32'hFFFF_FFF8);
      chk("wrap_g1", grant_log[1], 32'hFFFF_FFFC);
      chk("wrap_g2", grant_log[2], 32'h0000_0000);
    end

    // Reset with two outstanding; one return lands in reset, one after release
    step();
    stall = 1'b1;
    lat = 3;
    budget = 2;
    repeat (2) step();
    rst = 1'b1;
    step(); look();
    chk("mrst_valid", {31'h0, inst_valid}, 32'h0);
    chk("mrst_req", {31'h0, req}, 32'h0);
    step();
    rst = 1'b0;
    look();
    chk("mrst_rel_req", {31'h0, req}, 32'h1);
    chk("mrst_rel_addr", addr, 32'h0);
    step();
    stall = 1'b0;
    lat = 1;
    budget = 2;
    expect_words(32'h0, 2);
    drain("drain_mrst", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage of the RV32 core. It owns the fetch PC and issues word requests on the instruction bus, buffering returned instructions in a small in-order queue. It presents one instruction with its address per cycle to the if_id pipeline register, which feeds the decode stage. Redirects from jumps, branches and traps flush all in-flight work, and stalls from ctrl freeze the presented instruction.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 2: fetch queue entries; power of two, ≥2.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- stall_i  in  1  from ctrl; hold presented instruction.
- jump_flag_i  in  1  redirect request (jump/branch taken/trap).
- jump_addr_i  in  32  redirect target; bits [1:0] ignored (treated as 00).
- ibus_req_o  out  1  fetch request.
- ibus_addr_o  out  32  word address of request.
- ibus_gnt_i  in  1  request accepted this cycle.
- ibus_rvalid_i  in  1  read data valid; responses in request order.
- ibus_rdata_i  in  32  instruction word.
- inst_valid_o  out  1  inst_o/inst_addr_o hold a real instruction.
- inst_o  out  32  instruction to if_id; NOP (32'h0000_0013) when invalid.
- inst_addr_o  out  32  PC of inst_o.

## Operation
- State: fetch_pc (next request address), head_pc (PC of queue head), queue of DEPTH words, out_cnt (granted, not yet returned), disc_cnt (returns to drop), buf_cnt.
- Issue: ibus_req_o = !rst_i && (out_cnt + buf_cnt − pop) < DEPTH, where pop = inst_valid_o && !stall_i. ibus_addr_o = fetch_pc. On req && gnt: fetch_pc += 4 (wraps 32'hFFFF_FFFC → 0), out_cnt++.
- Bus rule: while req && !gnt, ibus_addr_o stays stable except in a flush cycle. Request is withdrawn or retargeted only on flush.
- Return: on rvalid, out_cnt−−. If disc_cnt > 0, drop the word and decrement disc_cnt. Otherwise push it to the queue tail. An rvalid with out_cnt == 0 is ignored.
- Present: inst_valid_o = buf_cnt > 0 (no combinational bypass from ibus_rdata_i). inst_o = queue head, inst_addr_o = head_pc. On pop: head advances and head_pc += 4.
- Stall: stall_i=1 → no pop; outputs hold. Fetching continues until credit is exhausted.
- Flush (jump_flag_i=1, priority over stall and pop):
  - fetch_pc and head_pc ← {jump_addr_i[31:2],2'b00}; buf_cnt ← 0.
  - disc_cnt ← out_cnt + (req&&gnt this cycle) − (rvalid this cycle, non-discarded or discarded). out_cnt keeps counting those words.
  - A request granted in the flush cycle carries the old address and is discarded.
- Reset: rst_i high → all counters 0, fetch_pc = head_pc = RESET_PC, queue invalid.
  - While rst_i is high, ibus_req_o=0, inst_valid_o=0, inst_o=NOP, and rvalid is ignored.

## Timing
- Reset values (while rst_i high and after the reset edge): ibus_req_o 0, ibus_addr_o RESET_PC, inst_valid_o 0, inst_o 32'h0000_0013, inst_addr_o RESET_PC.
- First cycle with rst_i low: ibus_req_o=1, ibus_addr_o=RESET_PC.
- Latency with zero-wait bus: gnt in cycle T, rvalid in T+1, inst_valid_o in T+2.
  - Redirect: jump_flag_i in cycle F, request to target in F+1, target presented in F+3 at the earliest.
- Throughput: DEPTH=2 with gnt always 1 and rvalid one cycle after gnt sustains one instruction per cycle with stall_i=0.
- Boundaries:
  - Queue full with stall → req low.
  - Push and pop in the same cycle with buf_cnt==DEPTH is legal and count unchanged.
  - Flush and rvalid in the same cycle → that word dropped.
  - Back-to-back flushes → last target wins, all prior returns dropped.
  - Reset mid-burst → outstanding words never presented.

## Test plan
- Reset release, gnt=1, rvalid next cycle, memory[a]=a^32'hA5A5_0000: inst_addr_o sequence 0,4,8,12… on consecutive cycles from cycle 3, inst_o matching; inst_valid_o stays 1.
- stall_i high 3 cycles while streaming: inst_o/inst_addr_o frozen, ibus_req_o drops once out_cnt+buf_cnt=2; after release, sequence resumes with no skipped or duplicated PC.
- Flush with 2 outstanding (rvalid delayed 3 cycles) to jump_addr_i=32'h0000_0103: both stale words dropped, next request address 32'h0000_0100, first valid inst_addr_o=32'h0000_0100.
- gnt held low 4 cycles: ibus_addr_o stable and ibus_req_o held until gnt; flush during wait retargets the address next cycle.
- fetch_pc at 32'hFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 issued; inst_addr_o wraps identically.
- rst_i asserted with 2 outstanding, late rvalids after release: ignored; first presented instruction is from RESET_PC.
